// File: rtl/trigger_out_capture_pkg.sv
// Shared constants and types for the trigger-out capture endpoint.
// Holds the default width, the endpoint address map and the response FSM state encoding.
package trigger_out_capture_pkg;

    localparam int          TRIG_WIDTH  = 16;
    localparam logic [7:0]  TRIG_EP_ADDR = 8'h60;
    // The overflow register sits directly above the trigger endpoint.
    localparam logic [7:0]  OVF_OFFSET  = 8'd1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } resp_state_t;

endpackage : trigger_out_capture_pkg

// File: rtl/trigger_out_capture_accumulator.sv
// Sticky accumulation of user trigger pulses with overflow tracking.
// A host update snapshots and clears both accumulators in one cycle.
module trigger_accumulator
    import trigger_out_capture_pkg::*;
#(
    parameter int WIDTH = TRIG_WIDTH
) (
    input  logic             ti_clock,
    input  logic             ti_reset,
    input  logic [WIDTH-1:0] ep_trigger,
    input  logic             ti_update,
    output logic [WIDTH-1:0] snap,
    output logic [WIDTH-1:0] ovf_snap,
    output logic             pending
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] ovf;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] ovf_next;

    // Pulses arriving in the update cycle belong to the snapshot being taken.
    assign acc_next = acc | ep_trigger;
    assign ovf_next = ovf | (acc & ep_trigger);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge ti_clock or posedge ti_reset) begin
        if (ti_reset) begin
            acc      <= '0;
            ovf      <= '0;
            snap     <= '0;
            ovf_snap <= '0;
        end else if (ti_update) begin
            snap     <= acc_next;
            ovf_snap <= ovf_next;
            acc      <= '0;
            ovf      <= '0;
        end else begin
            acc      <= acc_next;
            ovf      <= ovf_next;
        end
    end

    assign pending = |acc;

endmodule : trigger_accumulator

// File: rtl/trigger_out_capture.sv
// Device-to-host trigger endpoint: captures user pulses, snapshots on host update,
// and answers host reads at EP_ADDR (snapshot) and EP_ADDR+1 (overflow snapshot).
module trigger_out_capture
    import trigger_out_capture_pkg::*;
#(
    parameter int         WIDTH   = TRIG_WIDTH,
    parameter logic [7:0] EP_ADDR = TRIG_EP_ADDR
) (
    input  logic             ti_clock,
    input  logic             ti_reset,
    input  logic [WIDTH-1:0] ep_trigger,
    input  logic             ti_update,
    input  logic             ti_read,
    input  logic [7:0]       ti_addr,
    output logic [WIDTH-1:0] ti_dataout,
    output logic             ti_dataout_valid,
    output logic             trig_pending
);

    localparam logic [7:0] OVF_ADDR = EP_ADDR + OVF_OFFSET;

    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] ovf_snap;
    logic             hit_data;
    logic             hit_ovf;
    resp_state_t      state;
    logic [WIDTH-1:0] resp;
    logic             resp_valid;

    trigger_accumulator #(
        .WIDTH (WIDTH)
    ) u_acc (
        .ti_clock   (ti_clock),
        .ti_reset   (ti_reset),
        .ep_trigger (ep_trigger),
        .ti_update  (ti_update),
        .snap       (snap),
        .ovf_snap   (ovf_snap),
        .pending    (trig_pending)
    );

    assign hit_data = ti_read && (ti_addr == EP_ADDR);
    assign hit_ovf  = ti_read && (ti_addr == OVF_ADDR);

    // Response data is zeroed outside RESP so the output can be OR-combined
    // onto the shared host read bus. A read seen in RESP is accepted at once,
    // giving one response per cycle for back-to-back strobes.
    always_ff @(posedge ti_clock or posedge ti_reset) begin
        if (ti_reset) begin
            state      <= IDLE;
            resp       <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (hit_data || hit_ovf) begin
                        state      <= RESP;
                        resp       <= hit_data ? snap : ovf_snap;
                        resp_valid <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        resp       <= '0;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp       <= '0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ti_dataout       = resp;
    assign ti_dataout_valid = resp_valid;

endmodule : trigger_out_capture

// File: tb/tb_trigger_out_capture.sv
// Scoreboard bench for trigger_out_capture: stimulus pushes expected responses,
// a negedge monitor pops and compares data and arrival cycle.
module tb_trigger_out_capture;

    typedef struct {
        logic [15:0] data;
        int          cycle;
        string       name;
    } exp_t;

    logic        ti_clock = 1'b0;
    logic        ti_reset = 1'b1;
    logic [15:0] ep_trigger = '0;
    logic        ti_update = 1'b0;
    logic        ti_read = 1'b0;
    logic [7:0]  ti_addr = '0;
    logic [15:0] ti_dataout;
    logic        ti_dataout_valid;
    logic        trig_pending;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    trigger_out_capture dut (
        .ti_clock         (ti_clock),
        .ti_reset         (ti_reset),
        .ep_trigger       (ep_trigger),
        .ti_update        (ti_update),
        .ti_read          (ti_read),
        .ti_addr          (ti_addr),
        .ti_dataout       (ti_dataout),
        .ti_dataout_valid (ti_dataout_valid),
        .trig_pending     (trig_pending)
    );

    always #5 ti_clock = ~ti_clock;
    always @(posedge ti_clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every valid cycle must match the head of the scoreboard at the right cycle;
    // every idle cycle must show zero data.
    always @(negedge ti_clock) begin
        if (!ti_reset) begin
            if (ti_dataout_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(ti_dataout_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_data"}, 32'(ti_dataout), 32'(e.data));
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.cycle));
                end
            end else begin
                check("idle_data_zero", 32'(ti_dataout), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge ti_clock);
        #1;
    endtask

    task automatic pulse(input logic [15:0] v);
        ep_trigger = v;
        tick();
        ep_trigger = '0;
    endtask

    task automatic update(input logic [15:0] v);
        ti_update  = 1'b1;
        ep_trigger = v;
        tick();
        ti_update  = 1'b0;
        ep_trigger = '0;
    endtask

    task automatic read(input logic [7:0] addr, input logic expect_resp,
                        input logic [15:0] exp, input string name);
        ti_read = 1'b1;
        ti_addr = addr;
        if (expect_resp) sb.push_back('{data: exp, cycle: cyc + 1, name: name});
        tick();
        ti_read = 1'b0;
        ti_addr = '0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        check("reset_valid", 32'(ti_dataout_valid), 32'd0);
        check("reset_data", 32'(ti_dataout), 32'd0);
        check("reset_pending", 32'(trig_pending), 32'd0);
        ti_reset = 1'b0;
        tick();

        // Single pulse, update, read both registers.
        pulse(16'h0005);
        check("pending_after_pulse", 32'(trig_pending), 32'd1);
        update(16'h0000);
        check("pending_after_update", 32'(trig_pending), 32'd0);
        read(8'h60, 1'b1, 16'h0005, "t1_snap");
        read(8'h61, 1'b1, 16'h0000, "t1_ovf");
        drain("t1");

        // Re-trigger of a pending bit flags overflow.
        pulse(16'h0008);
        tick();
        pulse(16'h0008);
        update(16'h0000);
        read(8'h61, 1'b1, 16'h0008, "t2_ovf");
        read(8'h60, 1'b1, 16'h0008, "t2_snap");
        drain("t2");

        // Pulse in the update cycle lands in that snapshot; empty second update.
        update(16'h8000);
        read(8'h60, 1'b1, 16'h8000, "t3_snap");
        update(16'h0000);
        read(8'h60, 1'b1, 16'h0000, "t3_empty");
        drain("t3");

        // Read concurrent with update returns the pre-update snapshot.
        pulse(16'h00F0);
        update(16'h0000);
        ti_read    = 1'b1;
        ti_addr    = 8'h60;
        ti_update  = 1'b1;
        ep_trigger = 16'h0001;
        sb.push_back('{data: 16'h00F0, cycle: cyc + 1, name: "t4_old"});
        tick();
        ti_read = 1'b0; ti_update = 1'b0; ep_trigger = '0; ti_addr = '0;
        read(8'h60, 1'b1, 16'h0001, "t4_new");
        drain("t4");

        // Back-to-back reads, then a non-matching address.
        read(8'h60, 1'b1, 16'h0001, "t5_snap");
        read(8'h61, 1'b1, 16'h0000, "t5_ovf");
        read(8'h62, 1'b0, 16'h0000, "t5_miss");
        check("t5_miss_valid", 32'(ti_dataout_valid), 32'd0);
        check("t5_miss_data", 32'(ti_dataout), 32'd0);
        drain("t5");

        // Reset during RESP drops the response immediately.
        ti_read    = 1'b1;
        ti_addr    = 8'h60;
        ep_trigger = 16'h0003;
        tick();
        ti_read = 1'b0; ti_addr = '0; ep_trigger = '0;
        check("t6_in_resp", 32'(ti_dataout_valid), 32'd1);
        check("t6_pending_before", 32'(trig_pending), 32'd1);
        ti_reset = 1'b1;
        #1;
        check("t6_valid_dropped", 32'(ti_dataout_valid), 32'd0);
        check("t6_data_cleared", 32'(ti_dataout), 32'd0);
        check("t6_pending_cleared", 32'(trig_pending), 32'd0);
        @(negedge ti_clock);
        ti_reset = 1'b0;
        tick();
        update(16'h0000);
        read(8'h60, 1'b1, 16'h0000, "t6_after_reset");
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_trigger_out_capture

// File: doc/trigger_out_capture.md
# trigger_out_capture

Device-to-host counterpart of the host-to-device trigger endpoint: captures single-cycle trigger pulses raised by user logic and holds them until the host collects them. Pulses accumulate in a sticky register. A host update strobe snapshots and clears that register, and a host read at the endpoint address returns the snapshot on the host bus. Re-triggers of a bit that is still pending are flagged as overflow, so the host can see missed events. The block sits in the ti_clock domain between user logic and the host read mux.

## Interface
Parameters:
- WIDTH, 16, number of trigger bits
- EP_ADDR, 8'h60, trigger-out endpoint address; EP_ADDR+1 is the overflow register address

Ports:
- ti_clock  in  1  host-interface clock; all logic is on its rising edge
- ti_reset  in  1  asynchronous, active-high reset
- ep_trigger  in  WIDTH  user trigger pulses, one ti_clock cycle per event
- ti_update  in  1  host UpdateTriggerOuts strobe, one cycle
- ti_read  in  1  host read strobe
- ti_addr  in  8  host endpoint address
- ti_dataout  out  WIDTH  read data; zero when not responding, so it can be OR-combined on the bus
- ti_dataout_valid  out  1  high for exactly the one cycle in which ti_dataout carries the response
- trig_pending  out  1  OR of all accumulator bits, usable as an interrupt hint

## Operation
- Registers: acc, ovf, snap, ovf_snap (all WIDTH bits), plus the response FSM. Every register resets to 0.
- Cycle without ti_update:
  - acc <= acc | ep_trigger
  - ovf <= ovf | (acc & ep_trigger)
- Cycle with ti_update:
  - snap <= acc | ep_trigger; pulses arriving in the update cycle land in this snapshot, not the next
  - ovf_snap <= ovf | (acc & ep_trigger)
  - acc <= 0 and ovf <= 0
- Back-to-back updates: the second snapshot contains only pulses from the cycle(s) in between, including pulses in the second update cycle.
- Response FSM:
  - IDLE: in the cycle where ti_read=1 and ti_addr==EP_ADDR, latch resp <= snap. If ti_addr==EP_ADDR+1, latch resp <= ovf_snap. In either case go to RESP. Other addresses are ignored.
  - RESP: drive ti_dataout=resp and ti_dataout_valid=1 for one cycle, then return to IDLE. A matching ti_read seen during RESP is accepted: resp is reloaded and the FSM stays in RESP, so back-to-back reads give one response per cycle.
- Reads do not clear snap or ovf_snap; they can be re-read until the next update.
- Read and update in the same cycle: the read returns the pre-update snapshot.
- trig_pending is combinational from acc.
- ti_reset asserted mid-operation clears all registers and returns the FSM to IDLE immediately. ti_dataout_valid drops in the same instant; any pending response is lost.

## Timing
- Read latency: strobe in cycle N, data and valid in cycle N+1.
- Update to readable snapshot: update in cycle N; a read strobe in cycle N+1 returns the new snapshot in N+2.
- Pulse to trig_pending: pulse in cycle N, trig_pending high from N+1.
- Outputs while not in RESP: ti_dataout=0, ti_dataout_valid=0.

## Structure
- Shared package: WIDTH default, EP_ADDR base, overflow offset (1), and the FSM state enum {IDLE, RESP}.
- One sub-module is natural: trigger_accumulator, which holds acc and ovf and the update/snapshot logic, and outputs snap and ovf_snap. The top level adds the address decode and response FSM.

## Test plan
- Reset, then pulse ep_trigger=16'h0005 for one cycle; update; read EP_ADDR -> ti_dataout=16'h0005 with valid one cycle after the strobe; read EP_ADDR+1 -> 16'h0000.
- Pulse bit 3 in two separate cycles before an update; update; read EP_ADDR+1 -> 16'h0008, and EP_ADDR -> 16'h0008.
- ep_trigger=16'h8000 in the same cycle as ti_update -> that snapshot reads 16'h8000; a second update with no pulses -> reads 16'h0000.
- ti_read at EP_ADDR in the same cycle as an update that captures 16'h0001, with prior snap=16'h00F0 -> response 16'h00F0; the next read -> 16'h0001.
- Back-to-back reads at EP_ADDR, then EP_ADDR+1, then 8'h61+1 (non-matching) -> two consecutive valid cycles, then valid=0 with ti_dataout=0.
- Assert ti_reset during RESP -> valid drops immediately, trig_pending=0, and an update followed by a read returns 16'h0000.
